// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with MemReady stall handling, bus timeout and retired-instruction counter.
// Build option ILLEGAL_TRAP_EN: illegal encodings halt with IllegalInstr set instead of retiring as NOPs.
//
// state        | meaning
// FETCH     0  | read instruction at PC, load IR and PC+4 when MemReady
// DECODE    1  | latch OP/Function, precompute branch target
// MEM_ADDR  2  | ALU forms load/store address
// MEM_READ  3  | load access, waits for MemReady
// MEM_WB    4  | write loaded data to rt, retire
// MEM_WRITE 5  | store access, waits for MemReady, retire
// EXECUTE   6  | R-type or immediate ALU operation
// ALU_WB    7  | write ALU result, retire
// BRANCH    8  | compare rs/rt, conditional PC load, retire
// JUMP      9  | PC <= jump target, retire
// JAL      10  | PC <= jump target, $31 <= PC, retire
// JR       11  | PC <= rs, retire
// HALT     12  | bus timeout or trapped illegal instruction; reset only exit
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALUOP_WIDTH = 4,
  parameter int RETIRE_W    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic [5:0]             Function,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [1:0]             PCSource,
  output logic                   InstrDone,
  output logic [RETIRE_W-1:0]    Retired,
  output logic                   BusError,
  output logic                   IllegalInstr,
  output logic [3:0]             State
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_JR        = 4'd11,
    S_HALT      = 4'd12
  } stateT;

  typedef enum logic [3:0] {
    C_RTYPE, C_ITYPE, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILLEGAL
  } instrClassT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [3:0] ALU_ANDI  = 4'b0001;
  localparam logic [3:0] ALU_LW    = 4'b0010;
  localparam logic [3:0] ALU_SW    = 4'b0011;
  localparam logic [3:0] ALU_ADDI  = 4'b0100;
  localparam logic [3:0] ALU_ORI   = 4'b0101;
  localparam logic [3:0] ALU_LUI   = 4'b0110;
  localparam logic [3:0] ALU_RTYPE = 4'b0111;
  localparam logic [3:0] ALU_BEQ   = 4'b1000;
  localparam logic [3:0] ALU_BNE   = 4'b1001;
  localparam logic [3:0] ALU_PCADD = 4'b1010;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  function automatic instrClassT classify(input logic [5:0] op, input logic [5:0] fn);
    instrClassT cls;
    cls = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_AND, FN_OR, FN_NOR, FN_ADD, FN_SUB, FN_SLL, FN_SRL: cls = C_RTYPE;
          FN_JR:   cls = C_JR;
          default: cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: cls = C_ITYPE;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_BNE:  cls = C_BNE;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [3:0] immAluOp(input logic [5:0] op);
    logic [3:0] code;
    case (op)
      OP_ANDI: code = ALU_ANDI;
      OP_ORI:  code = ALU_ORI;
      OP_LUI:  code = ALU_LUI;
      default: code = ALU_ADDI;
    endcase
    return code;
  endfunction

  stateT             state, stateNext;
  logic [5:0]        opReg, fnReg;
  instrClassT        decodeCls, heldCls;
  logic [WAIT_W-1:0] waitCnt;
  logic              isMemState, memTimeout;
  logic              instrDoneReg, busErrReg;
  logic [RETIRE_W-1:0] retiredReg;

  logic       pcWrite, iorD, memRead, memWrite, irWrite, regWrite, aluSrcA;
  logic [1:0] regDst, memtoReg, aluSrcB, pcSource;
  logic [3:0] aluOpCode;
  logic       retireNow, busErrSet;
`ifdef ILLEGAL_TRAP_EN
  logic       illegalSet, illegalReg;
`endif

  assign decodeCls  = classify(OP, Function);
  assign heldCls    = classify(opReg, fnReg);
  assign isMemState = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  // The limit counts completed wait cycles; MemReady arriving in the cycle the limit is reached still succeeds.
  assign memTimeout = (MEM_TIMEOUT > 0) && (waitCnt == WAIT_LIMIT) && !MemReady;

  always_comb begin
    stateNext = state;
    pcWrite   = 1'b0;
    iorD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regDst    = 2'b00;
    memtoReg  = 2'b00;
    regWrite  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOpCode = 4'b0000;
    pcSource  = 2'b00;
    retireNow = 1'b0;
    busErrSet = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegalSet = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        memRead   = 1'b1;
        aluSrcB   = 2'b01;
        aluOpCode = ALU_PCADD;
        if (MemReady) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          stateNext = S_DECODE;
        end else if (memTimeout) begin
          busErrSet = 1'b1;
          stateNext = S_HALT;
        end
      end
      S_DECODE: begin
        aluSrcB   = 2'b11;
        aluOpCode = ALU_PCADD;
        case (decodeCls)
          C_LW, C_SW:       stateNext = S_MEM_ADDR;
          C_RTYPE, C_ITYPE: stateNext = S_EXECUTE;
          C_BEQ, C_BNE:     stateNext = S_BRANCH;
          C_J:              stateNext = S_JUMP;
          C_JAL:            stateNext = S_JAL;
          C_JR:             stateNext = S_JR;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            illegalSet = 1'b1;
            stateNext  = S_HALT;
`else
            retireNow  = 1'b1;
            stateNext  = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        aluOpCode = (heldCls == C_LW) ? ALU_LW : ALU_SW;
        stateNext = (heldCls == C_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (MemReady) begin
          stateNext = S_MEM_WB;
        end else if (memTimeout) begin
          busErrSet = 1'b1;
          stateNext = S_HALT;
        end
      end
      S_MEM_WB: begin
        memtoReg  = 2'b01;
        regWrite  = 1'b1;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_MEM_WRITE: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (MemReady) begin
          retireNow = 1'b1;
          stateNext = S_FETCH;
        end else if (memTimeout) begin
          busErrSet = 1'b1;
          stateNext = S_HALT;
        end
      end
      S_EXECUTE: begin
        aluSrcA   = 1'b1;
        aluSrcB   = (heldCls == C_RTYPE) ? 2'b00 : 2'b10;
        aluOpCode = (heldCls == C_RTYPE) ? ALU_RTYPE : immAluOp(opReg);
        stateNext = S_ALU_WB;
      end
      S_ALU_WB: begin
        regDst    = (heldCls == C_RTYPE) ? 2'b01 : 2'b00;
        regWrite  = 1'b1;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA   = 1'b1;
        aluOpCode = (heldCls == C_BEQ) ? ALU_BEQ : ALU_BNE;
        pcSource  = 2'b01;
        pcWrite   = (heldCls == C_BEQ) ? Zero : !Zero;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_JUMP: begin
        pcSource  = 2'b10;
        pcWrite   = 1'b1;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_JAL: begin
        pcSource  = 2'b10;
        pcWrite   = 1'b1;
        regDst    = 2'b10;
        memtoReg  = 2'b10;
        regWrite  = 1'b1;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_JR: begin
        pcSource  = 2'b11;
        pcWrite   = 1'b1;
        retireNow = 1'b1;
        stateNext = S_FETCH;
      end
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_FETCH;
      opReg        <= '0;
      fnReg        <= '0;
      waitCnt      <= '0;
      instrDoneReg <= 1'b0;
      retiredReg   <= '0;
      busErrReg    <= 1'b0;
    end else begin
      state        <= stateNext;
      instrDoneReg <= retireNow;
      if (state == S_DECODE) begin
        opReg <= OP;
        fnReg <= Function;
      end
      if (retireNow) retiredReg <= retiredReg + RETIRE_W'(1);
      if (busErrSet) busErrReg <= 1'b1;
      if (stateNext != state) begin
        waitCnt <= '0;
      end else if (isMemState && !MemReady && (waitCnt != WAIT_LIMIT)) begin
        waitCnt <= waitCnt + WAIT_W'(1);
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) illegalReg <= 1'b0;
    else if (illegalSet) illegalReg <= 1'b1;
  end
  assign IllegalInstr = !reset && illegalReg;
`else
  assign IllegalInstr = 1'b0;
`endif

  // Synchronous reset still forces every output low combinationally, so an aborted access strobes nothing.
  assign PCWrite   = !reset && pcWrite;
  assign IorD      = !reset && iorD;
  assign MemRead   = !reset && memRead;
  assign MemWrite  = !reset && memWrite;
  assign IRWrite   = !reset && irWrite;
  assign RegWrite  = !reset && regWrite;
  assign ALUSrcA   = !reset && aluSrcA;
  assign RegDst    = reset ? 2'b00 : regDst;
  assign MemtoReg  = reset ? 2'b00 : memtoReg;
  assign ALUSrcB   = reset ? 2'b00 : aluSrcB;
  assign PCSource  = reset ? 2'b00 : pcSource;
  assign ALUOp     = reset ? '0 : ALUOP_WIDTH'(aluOpCode);
  assign InstrDone = !reset && instrDoneReg;
  assign Retired   = reset ? '0 : retiredReg;
  assign BusError  = !reset && busErrReg;
  assign State     = reset ? 4'd0 : state;

endmodule
